rr_mux_arbiter_4: RTL

- Four-requester round-robin arbiter built around a 4:1 index-selected mux.
- Shares one W-bit output channel among four valid/ready sources and registers the selected word with its source index.
- Throughput is one transfer per cycle, with optional bounded bursts per source.
- Sits between independent producers and a single downstream consumer in the combinational-logic exercise datapath.

---
 rtl/rr_mux_pkg.sv | 13 +
 rtl/rr_pick_4.sv | 28 ++
 rtl/rr_mux_arbiter_4.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the four-source round-robin mux arbiter.
package rr_mux_pkg;

    localparam int N_SRC = 4;

    typedef logic [1:0] src_idx_t;

    // Circular successor of a source index (3 wraps to 0).
    function automatic src_idx_t next_idx(input src_idx_t i);
        return i + src_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational circular priority search: returns the first requesting
// index at or after `start`, wrapping from 3 back to 0.
module rr_pick_4
    import rr_mux_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  src_idx_t         start,
    output src_idx_t         gnt_idx,
    output logic             any
);

    src_idx_t idx;

    // Scan from the farthest offset down so the nearest requester wins
    always_comb begin
        gnt_idx = start;
        any     = 1'b0;
        idx     = '0;
        for (int off = N_SRC - 1; off >= 0; off--) begin
            idx = start + src_idx_t'(off);
            if (req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four-source round-robin arbiter sharing one registered W-bit channel.
// A source may hold the grant for up to BURST consecutive transfers
// while others wait; the selected word is captured with its index.
module rr_mux_arbiter_4
    import rr_mux_pkg::*;
#(
    parameter int W     = 4,
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] in_valid,
    input  logic [W-1:0]     in_data0,
    input  logic [W-1:0]     in_data1,
    input  logic [W-1:0]     in_data2,
    input  logic [W-1:0]     in_data3,
    output logic [N_SRC-1:0] in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    localparam int                CNT_W   = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    // Output register and arbitration state
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    src_idx_t         out_src_q,   out_src_d;
    src_idx_t         cur_q,       cur_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             load;
    src_idx_t         start;
    src_idx_t         gnt;
    logic             any;
    logic [W-1:0]     d [N_SRC];
    logic [W-1:0]     sel_data;

    // Index-addressed view of the four sources feeding the 4:1 mux
    always_comb begin
        d[0] = in_data0;
        d[1] = in_data1;
        d[2] = in_data2;
        d[3] = in_data3;
    end

    assign sel_data = d[gnt];

    // The output slot is free when empty or being drained this cycle
    assign load = ~out_valid_q | out_ready;

    // Move past the current source once it has used its whole burst
    always_comb begin
        start = (cnt_q == BURST_C) ? next_idx(cur_q) : cur_q;
    end

    rr_pick_4 u_pick (
        .req     (in_valid),
        .start   (start),
        .gnt_idx (gnt),
        .any     (any)
    );

    // One-hot ready to the winner; suppressed while held in reset
    always_comb begin
        in_ready = '0;
        if (rst_n && load && any) begin
            in_ready[gnt] = 1'b1;
        end
    end

    // Next-state: capture the winner, go empty on idle, hold under backpressure
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        if (load) begin
            if (any) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_src_d   = gnt;
                cur_d       = gnt;
                if (gnt == cur_q) begin
                    // Saturate: a lone requester can be re-granted past BURST
                    // but the count must stay at BURST so others still rotate in.
                    cnt_d = (cnt_q == BURST_C) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = CNT_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset leaves cur=3 with a full count so search starts at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            cur_q       <= src_idx_t'(N_SRC - 1);
            cnt_q       <= BURST_C;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
